uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver (and the TX side).
//   DATA_W          - character width (8N1 framing)
//   rx_state_e      - receiver FSM state encodings
//   calc_bit_clks() - clocks per bit from system clock and line rate
package uart_rx_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int calc_bit_clks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
// Resets to 1 so the line reads idle-high while in reset.
//   clk_i  - system clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronised output (2-edge latency)
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ack handshake, framing-error and
// sticky overrun flags. Optional parity: define UART_RX_PARITY_EN.
//   clockIN        - system clock
//   nResetIN       - asynchronous active-low reset
//   rxIN           - raw serial line, idle high
//   rxDataOUT      - received byte (LSB first on the line)
//   rxValidOUT     - byte available, held until rxAckIN
//   rxAckIN        - consumer acknowledge
//   rxFrameErrOUT  - stop bit sampled low for the byte in rxDataOUT
//   rxOverrunOUT   - a completed byte was dropped while rxValidOUT was high
//   rxParityErrOUT - parity mismatch (0 when parity is not built in)
//
// state      | meaning
// IDLE       | waiting for a low on the synchronised line
// START      | counting to mid start bit, rejecting glitches
// DATA       | sampling 8 data bits at mid-bit
// PARITY     | sampling the parity bit (parity build only)
// STOP       | sampling stop bit, delivering the byte
// WAIT_HIGH  | stop bit was low; hold off until the line returns high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 10_000_000,
  parameter int BAUD_RATE       = 115200
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD    = 1'b0
`endif
) (
  input  logic              clockIN,
  input  logic              nResetIN,
  input  logic              rxIN,
  output logic [DATA_W-1:0] rxDataOUT,
  output logic              rxValidOUT,
  input  logic              rxAckIN,
  output logic              rxFrameErrOUT,
  output logic              rxOverrunOUT,
  output logic              rxParityErrOUT
);

  localparam int BIT_CLKS  = calc_bit_clks(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CLKS - 1);

  if (BIT_CLKS < 4) begin : g_bit_clks_check
    $error("uart_rx: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
  end

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

  logic rx_sync;

  uart_rx_sync u_sync (
    .clk_i  (clockIN),
    .rst_ni (nResetIN),
    .d_i    (rxIN),
    .q_o    (rx_sync)
  );

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              ovr_q;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q;
  logic              par_err_q;
`endif

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      // Ack clears the handshake; a byte completing on the same edge
      // overrides this below and keeps valid high.
      if (rxAckIN && valid_q) begin
        valid_q     <= 1'b0;
        frame_err_q <= 1'b0;
        ovr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_q   <= 1'b0;
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_q <= ST_START;
            cnt_q   <= HALF_RELOAD;
          end
        end

        ST_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rx_sync) begin
            state_q <= ST_IDLE;
          end else begin
            state_q   <= ST_DATA;
            cnt_q     <= BIT_RELOAD;
            bit_idx_q <= '0;
          end
        end

        ST_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q   <= {rx_sync, shift_q[DATA_W-1:1]};
            cnt_q     <= BIT_RELOAD;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= AFTER_DATA;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            par_bad_q <= (^shift_q) ^ rx_sync ^ PARITY_ODD;
            cnt_q     <= BIT_RELOAD;
            state_q   <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!valid_q || rxAckIN) begin
              data_q      <= shift_q;
              valid_q     <= 1'b1;
              frame_err_q <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
              par_err_q   <= par_bad_q;
`endif
            end else begin
              ovr_q <= 1'b1;
            end
            // Leaving at mid-stop lets a following start bit be caught
            // with no idle gap.
            state_q <= rx_sync ? ST_IDLE : ST_WAIT_HIGH;
          end
        end

        ST_WAIT_HIGH: begin
          if (rx_sync) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rxDataOUT     = data_q;
  assign rxValidOUT    = valid_q;
  assign rxFrameErrOUT = frame_err_q;
  assign rxOverrunOUT  = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rxParityErrOUT = par_err_q;
`else
  assign rxParityErrOUT = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected bytes are queued by
// the stimulus and compared by a monitor when the DUT presents a byte.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       fe;
  logic       ovr;
  logic       pe;

  uart_rx #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD)
  ) dut (
    .clockIN        (clk),
    .nResetIN       (rst_n),
    .rxIN           (rx),
    .rxDataOUT      (data),
    .rxValidOUT     (valid),
    .rxAckIN        (ack),
    .rxFrameErrOUT  (fe),
    .rxOverrunOUT   (ovr),
    .rxParityErrOUT (pe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is presented when valid rises, or when the data changes
  // while valid stays high (ack coinciding with a new byte).
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (valid === 1'b1 && (prev_valid !== 1'b1 || data !== prev_data)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", {24'h0, data}, {24'h0, e.d});
        check("sb_frame_err", {31'h0, fe}, {31'h0, e.fe});
      end
    end
    prev_valid <= valid;
    prev_data  <= data;
  end

  // Called at a negedge; leaves the stop level on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_fe", {31'h0, fe}, 32'h0);
    check("rst_ovr", {31'h0, ovr}, 32'h0);
    check("rst_pe", {31'h0, pe}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5: valid must appear exactly on edge E0+95 (98th edge after the
    // start bit is driven, two of them spent in the synchroniser).
    sb.push_back('{d: 8'hA5, fe: 1'b0});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (97) @(posedge clk);
        @(negedge clk);
        check("a5_valid_early", {31'h0, valid}, 32'h0);
        @(negedge clk);
        check("a5_valid_on_time", {31'h0, valid}, 32'h1);
      end
    join
    wait_drain();
    ack_pulse();
    check("a5_ack_clears_valid", {31'h0, valid}, 32'h0);
    repeat (5) @(negedge clk);

    // False start: 3 clocks low.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("false_start_valid", {31'h0, valid}, 32'h0);

    // 0x3C with low stop bit, then line held low.
    sb.push_back('{d: 8'h3C, fe: 1'b1});
    send_frame(8'h3C, 1'b0);
    wait_drain();
    ack_pulse();
    check("fe_ack_clears_fe", {31'h0, fe}, 32'h0);
    repeat (50) @(negedge clk);
    check("held_low_no_byte", {31'h0, valid}, 32'h0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("released_no_byte", {31'h0, valid}, 32'h0);

    // Overrun: 0x11 then 0x22 with no ack.
    sb.push_back('{d: 8'h11, fe: 1'b0});
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    wait_drain();
    check("ovr_data_kept", {24'h0, data}, 32'h11);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    check("ovr_flag", {31'h0, ovr}, 32'h1);
    ack_pulse();
    check("ovr_ack_valid", {31'h0, valid}, 32'h0);
    check("ovr_ack_flag", {31'h0, ovr}, 32'h0);
    repeat (5) @(negedge clk);

    // Ack on the completion edge of the next byte.
    sb.push_back('{d: 8'h44, fe: 1'b0});
    send_frame(8'h44, 1'b1);
    wait_drain();
    sb.push_back('{d: 8'h55, fe: 1'b0});
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (97) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    wait_drain();
    check("same_edge_data", {24'h0, data}, 32'h55);
    check("same_edge_valid", {31'h0, valid}, 32'h1);
    check("same_edge_ovr", {31'h0, ovr}, 32'h0);

    // Reset mid-DATA of 0xFF while 0x55 is still pending.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_data", {24'h0, data}, 32'h0);
        check("mid_rst_valid", {31'h0, valid}, 32'h0);
        check("mid_rst_fe", {31'h0, fe}, 32'h0);
        check("mid_rst_ovr", {31'h0, ovr}, 32'h0);
      end
    join
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    sb.push_back('{d: 8'h81, fe: 1'b0});
    send_frame(8'h81, 1'b1);
    wait_drain();
    check("post_rst_data", {24'h0, data}, 32'h81);
    check("post_rst_valid", {31'h0, valid}, 32'h1);
    check("post_rst_pe", {31'h0, pe}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
